// File: rtl/adder_seq_nbit_pkg.sv
// Shared types and helpers for the sequential chunked adder/subtractor.
// State encodings are fixed so the FSM code can be matched against traces.
package adder_seq_nbit_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Chunk index counter width; a single-chunk build still gets one bit.
    function automatic int unsigned idx_width(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Legal when CHUNK is in [1, WIDTH] and divides WIDTH exactly.
    function automatic bit chunk_cfg_ok(input int unsigned w, input int unsigned c);
        return (c >= 1) && (c <= w) && ((w % c) == 0);
    endfunction

endpackage

// File: rtl/adder_seq_nbit_chunk.sv
// Combinational CHUNK-bit ripple adder slice used once per clock by the top.
// cmsb is the carry into the slice MSB, needed for signed overflow.
module adder_chunk
    import adder_seq_nbit_pkg::*;
#(
    parameter int unsigned CHUNK = 4
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] s,
    output logic             cout,
    output logic             cmsb
);

    logic [CHUNK:0] sum;

    // Single CHUNK-bit add; carry into MSB recovered from the MSB sum bit.
    always_comb begin
        sum  = {1'b0, a} + {1'b0, b} + {{CHUNK{1'b0}}, cin};
        s    = sum[CHUNK-1:0];
        cout = sum[CHUNK];
        cmsb = a[CHUNK-1] ^ b[CHUNK-1] ^ sum[CHUNK-1];
    end

endmodule

// File: rtl/adder_seq_nbit.sv
// Multi-cycle WIDTH-bit adder/subtractor processing CHUNK bits per clock,
// LSB chunk first, with the carry held in a flop between chunks.
// Optional feature: define ADDER_SEQ_OVF_EN to add the signed overflow output ovf.
module adder_seq_nbit
    import adder_seq_nbit_pkg::*;
#(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned CHUNK = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sub,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
`ifdef ADDER_SEQ_OVF_EN
    output logic             ovf,
`endif
    output logic             cout
);

    localparam int unsigned N    = WIDTH / CHUNK;
    localparam int unsigned IDXW = idx_width(N);

    // Elaboration-time guard against an illegal WIDTH/CHUNK pairing.
    if (!chunk_cfg_ok(WIDTH, CHUNK)) begin : g_bad_cfg
        $error("adder_seq_nbit: WIDTH must be a positive multiple of CHUNK");
    end

    state_e            state_q;
    logic [WIDTH-1:0]  a_q;
    logic [WIDTH-1:0]  b_q;
    logic [WIDTH-1:0]  part_q;
    logic [WIDTH-1:0]  part_next;
    logic              carry_q;
    logic [IDXW-1:0]   idx_q;
    logic              last_chunk;
    logic              busy_q;
    logic              done_q;
    logic [WIDTH-1:0]  s_q;
    logic              cout_q;

    logic [CHUNK-1:0]  ch_s;
    logic              ch_cout;
    logic              ch_cmsb;

    // The low chunk of the shifting operand registers is always the one in flight.
    adder_chunk #(
        .CHUNK (CHUNK)
    ) u_chunk (
        .a    (a_q[CHUNK-1:0]),
        .b    (b_q[CHUNK-1:0]),
        .cin  (carry_q),
        .s    (ch_s),
        .cout (ch_cout),
        .cmsb (ch_cmsb)
    );

    // Partial result fills from the top; after N steps it is fully aligned.
    always_comb begin
        part_next  = (part_q >> CHUNK) | (WIDTH'(ch_s) << (WIDTH - CHUNK));
        last_chunk = (idx_q == IDXW'(N - 1));
    end

`ifdef ADDER_SEQ_OVF_EN
    logic ovf_q;

    // Overflow flag, updated only on the completion edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state_q == ST_BUSY && last_chunk) begin
            ovf_q <= ch_cmsb ^ ch_cout;
        end
    end

    assign ovf = ovf_q;
`else
    logic unused_cmsb;
    assign unused_cmsb = ch_cmsb;
`endif

    // Control FSM with datapath registers and registered busy/done/s/cout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            part_q  <= '0;
            carry_q <= 1'b0;
            idx_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            s_q     <= '0;
            cout_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        a_q     <= a;
                        b_q     <= sub ? ~b : b;
                        carry_q <= sub ? 1'b1 : cin;
                        part_q  <= '0;
                        idx_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= ST_BUSY;
                    end else begin
                        busy_q  <= 1'b0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_BUSY: begin
                    a_q     <= a_q >> CHUNK;
                    b_q     <= b_q >> CHUNK;
                    part_q  <= part_next;
                    carry_q <= ch_cout;
                    if (last_chunk) begin
                        s_q     <= part_next;
                        cout_q  <= ch_cout;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= ST_DONE;
                    end else begin
                        idx_q <= idx_q + IDXW'(1);
                    end
                end
                default: begin
                    busy_q  <= 1'b0;
                    done_q  <= 1'b0;
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_adder_seq_nbit.sv
// Self-checking bench for adder_seq_nbit: directed tests on WIDTH=16/CHUNK=4
// plus a random sweep over 8/8, 16/1 and 32/8 builds sharing the same stimulus.
module tb_adder_seq_nbit;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        sub   = 1'b0;
    logic        cin   = 1'b0;
    logic [31:0] a     = '0;
    logic [31:0] b     = '0;

    logic        busy16, done16, cout16;
    logic [15:0] s16;
    logic        busy8, done8, cout8;
    logic [7:0]  s8;
    logic        busyc1, donec1, coutc1;
    logic [15:0] sc1;
    logic        busy32, done32, cout32;
    logic [31:0] s32;
`ifdef ADDER_SEQ_OVF_EN
    logic        ovf16;
    logic        unused_ovf8, unused_ovfc1, unused_ovf32;
`endif

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    adder_seq_nbit #(.WIDTH(16), .CHUNK(4)) u16 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]),
        .cin(cin), .busy(busy16), .done(done16), .s(s16),
`ifdef ADDER_SEQ_OVF_EN
        .ovf(ovf16),
`endif
        .cout(cout16)
    );

    adder_seq_nbit #(.WIDTH(8), .CHUNK(8)) u8 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[7:0]), .b(b[7:0]),
        .cin(cin), .busy(busy8), .done(done8), .s(s8),
`ifdef ADDER_SEQ_OVF_EN
        .ovf(unused_ovf8),
`endif
        .cout(cout8)
    );

    adder_seq_nbit #(.WIDTH(16), .CHUNK(1)) uc1 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a[15:0]), .b(b[15:0]),
        .cin(cin), .busy(busyc1), .done(donec1), .s(sc1),
`ifdef ADDER_SEQ_OVF_EN
        .ovf(unused_ovfc1),
`endif
        .cout(coutc1)
    );

    adder_seq_nbit #(.WIDTH(32), .CHUNK(8)) u32 (
        .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
        .cin(cin), .busy(busy32), .done(done32), .s(s32),
`ifdef ADDER_SEQ_OVF_EN
        .ovf(unused_ovf32),
`endif
        .cout(cout32)
    );

    // Reference: full (w+1)-bit sum of the masked operands.
    function automatic logic [32:0] ref_sum(input int w, input logic [31:0] va,
                                            input logic [31:0] vb, input logic vsub,
                                            input logic vcin);
        logic [32:0] m;
        logic [31:0] bb;
        m  = (33'd1 << w) - 33'd1;
        bb = vsub ? ~vb : vb;
        return ({1'b0, va} & m) + ({1'b0, bb} & m) + {32'd0, (vsub ? 1'b1 : vcin)};
    endfunction

    // Present one start pulse; returns at the negedge after the accepting edge.
    task automatic launch(input logic vsub, input logic [31:0] va, input logic [31:0] vb,
                          input logic vcin);
        @(negedge clk);
        start = 1'b1;
        sub   = vsub;
        a     = va;
        b     = vb;
        cin   = vcin;
        @(negedge clk);
        start = 1'b0;
    endtask

    // Count edges after acceptance until done16 is seen; -1 on timeout.
    task automatic wait_done16(output int lat);
        lat = -1;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset;
        @(negedge clk);
        total++;
        if ({busy16, done16, cout16, s16} !== 19'd0)
            $display("FAIL reset_state: got busy=%b done=%b cout=%b s=%h, want all 0",
                     busy16, done16, cout16, s16);
        else passed++;
        rst_n = 1'b1;
        @(negedge clk);
        total++;
        if ({busy16, done16} !== 2'b00)
            $display("FAIL idle_after_reset: got busy=%b done=%b, want 0 0", busy16, done16);
        else passed++;
    endtask

    task automatic run_directed(input string name, input logic vsub, input logic [15:0] va,
                                input logic [15:0] vb, input logic vcin,
                                input logic [15:0] es, input logic ec, input logic eovf);
        int lat;
        launch(vsub, {16'd0, va}, {16'd0, vb}, vcin);
        total++;
        if (busy16 !== 1'b1) $display("FAIL %s_busy: got %b, want 1", name, busy16);
        else passed++;
        wait_done16(lat);
        total++;
        if (lat !== 4) $display("FAIL %s_latency: got %0d, want 4", name, lat);
        else passed++;
        total++;
        if ({cout16, s16} !== {ec, es})
            $display("FAIL %s_result: got cout=%b s=%h, want cout=%b s=%h",
                     name, cout16, s16, ec, es);
        else passed++;
`ifdef ADDER_SEQ_OVF_EN
        total++;
        if (ovf16 !== eovf) $display("FAIL %s_ovf: got %b, want %b", name, ovf16, eovf);
        else passed++;
`else
        if (eovf === 1'bx) $display("unexpected x in expected ovf");
`endif
        @(negedge clk);
        total++;
        if ({busy16, done16} !== 2'b00 || s16 !== es)
            $display("FAIL %s_pulse_hold: got busy=%b done=%b s=%h, want 0 0 %h",
                     name, busy16, done16, s16, es);
        else passed++;
    endtask

    task automatic test_add;
        run_directed("add_ffff_1", 1'b0, 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0);
        run_directed("add_7fff_1", 1'b0, 16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1);
        run_directed("add_cin", 1'b0, 16'h1234, 16'h4321, 1'b1, 16'h5556, 1'b0, 1'b0);
    endtask

    task automatic test_sub;
        run_directed("sub_5_7", 1'b1, 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0);
        run_directed("sub_7_5", 1'b1, 16'h0007, 16'h0005, 1'b0, 16'h0002, 1'b1, 1'b0);
    endtask

    task automatic test_busy_ignore;
        int lat;
        lat = -1;
        launch(1'b0, 32'h1000, 32'h0200, 1'b0);
        for (int k = 1; k <= 12; k++) begin
            @(negedge clk);
            if (done16 === 1'b1) begin
                lat   = k;
                start = 1'b0;
                break;
            end
            start = 1'b1;
            sub   = 1'b1;
            a     = 32'h0000_0F0F + k;
            b     = 32'h0000_3333 << k;
        end
        start = 1'b0;
        total++;
        if (lat !== 4 || s16 !== 16'h1200 || cout16 !== 1'b0)
            $display("FAIL busy_ignore: got lat=%0d s=%h cout=%b, want 4 1200 0",
                     lat, s16, cout16);
        else passed++;
        @(negedge clk);
        @(negedge clk);
        total++;
        if ({busy16, done16} !== 2'b00 || s16 !== 16'h1200)
            $display("FAIL busy_ignore_no_restart: got busy=%b done=%b s=%h, want 0 0 1200",
                     busy16, done16, s16);
        else passed++;
    endtask

    task automatic test_back_to_back;
        int lat;
        launch(1'b0, 32'h0001, 32'h0002, 1'b0);
        wait_done16(lat);
        start = 1'b1;
        a     = 32'h0100;
        b     = 32'h0011;
        @(negedge clk);
        start = 1'b0;
        total++;
        if (busy16 !== 1'b1 || done16 !== 1'b0 || s16 !== 16'h0003)
            $display("FAIL b2b_accept: got busy=%b done=%b s=%h, want 1 0 0003",
                     busy16, done16, s16);
        else passed++;
        wait_done16(lat);
        total++;
        if (lat !== 4 || s16 !== 16'h0111)
            $display("FAIL b2b_second: got lat=%0d s=%h, want 4 0111", lat, s16);
        else passed++;
    endtask

    task automatic test_reset_mid;
        int seen;
        seen = 0;
        launch(1'b0, 32'h00FF, 32'h0F0F, 1'b0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        total++;
        if ({busy16, done16, cout16, s16} !== 19'd0)
            $display("FAIL reset_mid: got busy=%b done=%b cout=%b s=%h, want all 0",
                     busy16, done16, cout16, s16);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            if (done16 === 1'b1 || busy16 === 1'b1) seen++;
        end
        total++;
        if (seen !== 0 || s16 !== 16'h0000)
            $display("FAIL reset_mid_discard: got %0d busy/done cycles s=%h, want 0 0000",
                     seen, s16);
        else passed++;
    endtask

    task automatic test_sweep;
        logic [31:0] va, vb;
        logic        vs, vc;
        logic [32:0] f8, f16, f32;
        int          l8, lc1, l32, l16;
        for (int i = 0; i < 1000; i++) begin
            va = $urandom;
            vb = $urandom;
            vs = 1'($urandom & 1);
            vc = 1'($urandom & 1);
            f8  = ref_sum(8, va, vb, vs, vc);
            f16 = ref_sum(16, va, vb, vs, vc);
            f32 = ref_sum(32, va, vb, vs, vc);
            l8 = -1; lc1 = -1; l32 = -1; l16 = -1;
            launch(vs, va, vb, vc);
            for (int k = 1; k <= 20; k++) begin
                @(negedge clk);
                if (done8 === 1'b1 && l8 < 0) l8 = k;
                if (donec1 === 1'b1 && lc1 < 0) lc1 = k;
                if (done32 === 1'b1 && l32 < 0) l32 = k;
                if (done16 === 1'b1 && l16 < 0) l16 = k;
            end
            total++;
            if (l8 !== 1 || {cout8, s8} !== f8[8:0])
                $display("FAIL sweep_w8c8[%0d]: got lat=%0d %b_%h, want 1 %b_%h",
                         i, l8, cout8, s8, f8[8], f8[7:0]);
            else passed++;
            total++;
            if (lc1 !== 16 || {coutc1, sc1} !== f16[16:0])
                $display("FAIL sweep_w16c1[%0d]: got lat=%0d %b_%h, want 16 %b_%h",
                         i, lc1, coutc1, sc1, f16[16], f16[15:0]);
            else passed++;
            total++;
            if (l32 !== 4 || {cout32, s32} !== f32)
                $display("FAIL sweep_w32c8[%0d]: got lat=%0d %b_%h, want 4 %b_%h",
                         i, l32, cout32, s32, f32[32], f32[31:0]);
            else passed++;
            total++;
            if (l16 !== 4 || {cout16, s16} !== f16[16:0])
                $display("FAIL sweep_w16c4[%0d]: got lat=%0d %b_%h, want 4 %b_%h",
                         i, l16, cout16, s16, f16[16], f16[15:0]);
            else passed++;
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_sub();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_sweep();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
